// File: rtl/sargantana_icache_replace_ctrl_if.sv
// sargantana_icache_replace_ctrl_if: core-side and RAM-side signals of the icache replacement controller.
interface sargantana_icache_replace_ctrl_if #(
    parameter int ICACHE_N_WAY     = 4,
    parameter int ICACHE_IDX_WIDTH = 6
);
    localparam int W = $clog2(ICACHE_N_WAY);
    logic                        flush_req_i;
    logic                        busy_o;
    logic                        flush_done_o;
    logic                        inval_valid_i;
    logic [ICACHE_IDX_WIDTH-1:0] inval_idx_i;
    logic                        inval_ready_o;
    logic                        cache_rd_ena_i;
    logic                        cache_wr_ena_i;
    logic [ICACHE_IDX_WIDTH-1:0] cline_index_i;
    logic [ICACHE_N_WAY-1:0]     way_valid_bits_i;
    logic                        cmp_en_i;
    logic                        hit_i;
    logic [W-1:0]                hit_way_i;
    logic [W-1:0]                way_to_replace_o;
    logic [ICACHE_IDX_WIDTH-1:0] addr_valid_o;
    logic [ICACHE_N_WAY-1:0]     tag_req_valid_o;
    logic [ICACHE_N_WAY-1:0]     data_req_valid_o;
    logic                        we_valid_o;
    logic                        valid_bit_o;
    modport slave (
        input  flush_req_i, inval_valid_i, inval_idx_i, cache_rd_ena_i, cache_wr_ena_i,
               cline_index_i, way_valid_bits_i, cmp_en_i, hit_i, hit_way_i,
        output busy_o, flush_done_o, inval_ready_o, way_to_replace_o, addr_valid_o,
               tag_req_valid_o, data_req_valid_o, we_valid_o, valid_bit_o
    );
    modport master (
        output flush_req_i, inval_valid_i, inval_idx_i, cache_rd_ena_i, cache_wr_ena_i,
               cline_index_i, way_valid_bits_i, cmp_en_i, hit_i, hit_way_i,
        input  busy_o, flush_done_o, inval_ready_o, way_to_replace_o, addr_valid_o,
               tag_req_valid_o, data_req_valid_o, we_valid_o, valid_bit_o
    );
endinterface

// File: rtl/sargantana_icache_replace_ctrl.sv
// sargantana_icache_replace_ctrl: icache victim selection, flush sweep and valid-bit RAM commands.
// Define ICACHE_PLRU_EN for per-set tree PLRU; otherwise a 16-bit LFSR picks victims.
module sargantana_icache_replace_ctrl #(
    parameter int ICACHE_N_WAY     = 4,
    parameter int ICACHE_IDX_WIDTH = 6
) (
    input logic clk_i,
    input logic rstn_i,
    sargantana_icache_replace_ctrl_if.slave bus
);
    localparam int W     = $clog2(ICACHE_N_WAY);
    localparam int NT    = ICACHE_N_WAY - 1;
    localparam int N_SET = 1 << ICACHE_IDX_WIDTH;
    typedef enum logic [1:0] {IDLE, FLUSH, DONE} state_e;
    state_e                      state_q, state_d;
    logic [ICACHE_IDX_WIDTH-1:0] cnt_q, cnt_d;
    logic [W-1:0]                way_q, way_d, inv_way, pol_way;
    logic [ICACHE_N_WAY-1:0]     way_oh, inv_bits, inv_sh;
    logic                        flush_act, inv_acc, wr_cmd, rd_cmd;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            way_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            way_q   <= way_d;
        end
    end

    always_comb begin
        state_d = state_q == IDLE  ? (bus.flush_req_i ? FLUSH : IDLE) :
                  state_q == FLUSH ? (cnt_q == '1 ? DONE : FLUSH) : IDLE;
        cnt_d   = state_q == FLUSH ? cnt_q + 1'b1 : '0;
    end

    always_comb begin
        bus.busy_o        = state_q == FLUSH;
        bus.flush_done_o  = state_q == DONE;
        bus.inval_ready_o = state_q == IDLE && !bus.flush_req_i;
    end

    // One RAM command per cycle: sweep, then invalidation, then refill, then lookup
    always_comb begin
        flush_act            = state_q == FLUSH;
        inv_acc              = bus.inval_valid_i & bus.inval_ready_o;
        wr_cmd               = bus.cache_wr_ena_i & ~flush_act & ~inv_acc;
        rd_cmd               = bus.cache_rd_ena_i & ~bus.cache_wr_ena_i & ~flush_act & ~inv_acc;
        way_oh               = ICACHE_N_WAY'(1) << way_q;
        bus.addr_valid_o     = flush_act ? cnt_q : inv_acc ? bus.inval_idx_i : bus.cline_index_i;
        bus.tag_req_valid_o  = (flush_act | inv_acc | rd_cmd) ? '1 : wr_cmd ? way_oh : '0;
        bus.data_req_valid_o = wr_cmd ? way_oh : rd_cmd ? '1 : '0;
        bus.we_valid_o       = flush_act | inv_acc | wr_cmd;
        bus.valid_bit_o      = wr_cmd;
        bus.way_to_replace_o = way_q;
    end

    always_comb begin
        inv_way  = '0;
        inv_sh   = '0;
        inv_bits = ~bus.way_valid_bits_i;
        for (int i = ICACHE_N_WAY - 1; i >= 0; i--) begin
            inv_sh = inv_bits >> i;
            if (inv_sh[0]) inv_way = W'(i);
        end
        way_d = bus.cmp_en_i ? (&bus.way_valid_bits_i ? pol_way : inv_way) : way_q;
    end

`ifdef ICACHE_PLRU_EN
    logic [N_SET-1:0][NT-1:0] plru_q, plru_d;

    function automatic logic [W-1:0] plru_victim(input logic [NT-1:0] t);
        logic [NT-1:0] ts;
        int            n;
        n = 0;
        for (int l = 0; l < W; l++) begin
            ts = t >> n;
            n  = 2 * n + 1 + int'(ts[0]);
        end
        return W'(n - NT);
    endfunction

    // Each node on the path is pointed at the sibling subtree of the accessed way
    function automatic logic [NT-1:0] plru_touch(input logic [NT-1:0] t, input logic [W-1:0] w);
        logic [NT-1:0] r;
        logic [W-1:0]  ws;
        int            n;
        r = t;
        n = 0;
        for (int l = 0; l < W; l++) begin
            ws = w >> (W - 1 - l);
            r  = (r & ~(NT'(1) << n)) | (NT'(~ws[0]) << n);
            n  = 2 * n + 1 + int'(ws[0]);
        end
        return r;
    endfunction

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) plru_q <= '0;
        else plru_q <= plru_d;
    end

    always_comb begin
        plru_d = plru_q;
        if (flush_act) plru_d[cnt_q] = '0;
        else if (inv_acc) plru_d[bus.inval_idx_i] = '0;
        else if (wr_cmd) plru_d[bus.cline_index_i] = plru_touch(plru_q[bus.cline_index_i], way_q);
        else if (rd_cmd & bus.hit_i) plru_d[bus.cline_index_i] = plru_touch(plru_q[bus.cline_index_i], bus.hit_way_i);
        pol_way = plru_victim(plru_q[bus.cline_index_i]);
    end
`else
    logic [15:0] lfsr_q, lfsr_d;
    logic        full_q, full_d;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            lfsr_q <= 16'hACE1;
            full_q <= 1'b0;
        end else begin
            lfsr_q <= lfsr_d;
            full_q <= full_d;
        end
    end

    // Only refills that displaced a valid line consume randomness
    always_comb begin
        lfsr_d  = (wr_cmd & full_q) ? {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]} : lfsr_q;
        full_d  = bus.cmp_en_i ? &bus.way_valid_bits_i : full_q;
        pol_way = lfsr_q[W-1:0];
    end
`endif
endmodule

// File: tb/tb_sargantana_icache_replace_ctrl.sv
// tb_sargantana_icache_replace_ctrl: scoreboard bench against a behavioural model of the replacement controller.
module tb_sargantana_icache_replace_ctrl;
    localparam int NW = 4;
    localparam int IW = 6;
    localparam int NS = 64;

    logic clk = 1'b1;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    sargantana_icache_replace_ctrl_if #(.ICACHE_N_WAY(NW), .ICACHE_IDX_WIDTH(IW)) bus();
    sargantana_icache_replace_ctrl #(.ICACHE_N_WAY(NW), .ICACHE_IDX_WIDTH(IW)) dut (
        .clk_i(clk), .rstn_i(rstn), .bus(bus)
    );

    typedef struct {
        int addr, tag, data, we, vb, busy, done, ready, way;
    } exp_t;
    exp_t q[$];
    int checks = 0, errors = 0;

    int sweep, done_m, way_m, full_m, lfsr_m;
    int tree[NS][3];

    function automatic void model_reset();
        sweep = -1; done_m = 0; way_m = 0; full_m = 0; lfsr_m = 'hACE1;
        for (int s = 0; s < NS; s++) for (int n = 0; n < 3; n++) tree[s][n] = 0;
    endfunction

    function automatic int plru_vic(int s);
        int n = 0;
        for (int l = 0; l < 2; l++) n = 2 * n + 1 + tree[s][n];
        return n - 3;
    endfunction

    function automatic void plru_acc(int s, int w);
        int n = 0;
        for (int l = 0; l < 2; l++) begin
            int d = (w >> (1 - l)) & 1;
            tree[s][n] = 1 - d;
            n = 2 * n + 1 + d;
        end
    endfunction

    function automatic void chk(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endfunction

    task automatic step();
        exp_t e;
        int cl, v, nway, nfull, acc, flushing;
        if (!rstn) model_reset();
        cl = int'(bus.cline_index_i);
        v = int'(bus.way_valid_bits_i);
        flushing = sweep >= 0 ? 1 : 0;
        e.busy = flushing; e.done = done_m; e.way = way_m;
        e.ready = (!flushing && !done_m && !bus.flush_req_i) ? 1 : 0;
        acc = (bus.inval_valid_i && e.ready) ? 1 : 0;
        e.addr = cl; e.tag = 0; e.data = 0; e.we = 0; e.vb = 0;
        if (flushing) begin e.addr = sweep; e.tag = 'hF; e.we = 1; end
        else if (acc) begin e.addr = int'(bus.inval_idx_i); e.tag = 'hF; e.we = 1; end
        else if (bus.cache_wr_ena_i) begin e.tag = 1 << way_m; e.data = 1 << way_m; e.we = 1; e.vb = 1; end
        else if (bus.cache_rd_ena_i) begin e.tag = 'hF; e.data = 'hF; end
        q.push_back(e);
        if (!rstn) return;
        nway = way_m; nfull = full_m;
        if (bus.cmp_en_i) begin
            nfull = v == 'hF ? 1 : 0;
            if (v != 'hF) begin
                for (int i = 3; i >= 0; i--) if (((v >> i) & 1) == 0) nway = i;
            end else begin
`ifdef ICACHE_PLRU_EN
                nway = plru_vic(cl);
`else
                nway = lfsr_m & 3;
`endif
            end
        end
        if (flushing) for (int n = 0; n < 3; n++) tree[sweep][n] = 0;
        else if (acc) for (int n = 0; n < 3; n++) tree[int'(bus.inval_idx_i)][n] = 0;
        else if (bus.cache_wr_ena_i) begin
            plru_acc(cl, way_m);
            if (full_m != 0) begin
                int b = (lfsr_m ^ (lfsr_m >> 2) ^ (lfsr_m >> 3) ^ (lfsr_m >> 5)) & 1;
                lfsr_m = (lfsr_m >> 1) | (b << 15);
            end
        end else if (bus.cache_rd_ena_i && bus.hit_i) plru_acc(cl, int'(bus.hit_way_i));
        way_m = nway; full_m = nfull;
        if (flushing) begin
            if (sweep == NS - 1) begin sweep = -1; done_m = 1; end
            else sweep++;
        end else if (done_m != 0) done_m = 0;
        else if (bus.flush_req_i) sweep = 0;
    endtask

    task automatic cyc();
        step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.flush_req_i = 0; bus.inval_valid_i = 0; bus.inval_idx_i = '0;
        bus.cache_rd_ena_i = 0; bus.cache_wr_ena_i = 0; bus.cline_index_i = '0;
        bus.way_valid_bits_i = '1; bus.cmp_en_i = 0; bus.hit_i = 0; bus.hit_way_i = '0;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("addr_valid", int'(bus.addr_valid_o), e.addr);
                chk("tag_req", int'(bus.tag_req_valid_o), e.tag);
                chk("data_req", int'(bus.data_req_valid_o), e.data);
                chk("we_valid", int'(bus.we_valid_o), e.we);
                chk("valid_bit", int'(bus.valid_bit_o), e.vb);
                chk("busy", int'(bus.busy_o), e.busy);
                chk("flush_done", int'(bus.flush_done_o), e.done);
                chk("inval_ready", int'(bus.inval_ready_o), e.ready);
                chk("way_to_replace", int'(bus.way_to_replace_o), e.way);
            end
        end
    end

    initial begin
        model_reset();
        idle_inputs();
        repeat (3) cyc();
        rstn = 1;
        cyc();
        bus.flush_req_i = 1; cyc(); bus.flush_req_i = 0;
        repeat (NS + 3) cyc();
        bus.way_valid_bits_i = 4'b1011; bus.cmp_en_i = 1; bus.cline_index_i = 6'd9; cyc();
        bus.cmp_en_i = 0; bus.cache_wr_ena_i = 1; cyc();
        bus.cache_wr_ena_i = 0; cyc();
        bus.way_valid_bits_i = '1; bus.cline_index_i = 6'd5;
        bus.cache_rd_ena_i = 1; bus.hit_i = 1; bus.hit_way_i = 2'd0; cyc();
        bus.cache_rd_ena_i = 0; bus.hit_i = 0; bus.cmp_en_i = 1; cyc();
        bus.cmp_en_i = 0; cyc();
        bus.cache_rd_ena_i = 1; bus.hit_i = 1; bus.hit_way_i = 2'd2; cyc();
        bus.cache_rd_ena_i = 0; bus.hit_i = 0; bus.cmp_en_i = 1; cyc();
        bus.cmp_en_i = 0; cyc();
        bus.flush_req_i = 1; cyc(); bus.flush_req_i = 0;
        bus.inval_valid_i = 1; bus.inval_idx_i = 6'd5;
        repeat (NS + 3) cyc();
        bus.inval_valid_i = 0; bus.cmp_en_i = 1; bus.cline_index_i = 6'd5; cyc();
        bus.cmp_en_i = 0; cyc();
        bus.flush_req_i = 1; bus.inval_valid_i = 1; bus.inval_idx_i = 6'd2;
        bus.cache_rd_ena_i = 1; bus.cline_index_i = 6'd7; cyc();
        idle_inputs();
        repeat (NS + 3) cyc();
        bus.cline_index_i = 6'd3; bus.cmp_en_i = 1; cyc();
        bus.cmp_en_i = 0; bus.cache_rd_ena_i = 1; bus.cache_wr_ena_i = 1; bus.hit_i = 1; bus.hit_way_i = 2'd1; cyc();
        bus.cache_rd_ena_i = 0; bus.cache_wr_ena_i = 0; bus.hit_i = 0; bus.cmp_en_i = 1; cyc();
        bus.cmp_en_i = 0; cyc();
        bus.flush_req_i = 1; cyc(); bus.flush_req_i = 0;
        for (int k = 0; k < 100 && sweep != 20; k++) cyc();
        rstn = 0; cyc(); cyc();
        rstn = 1; cyc();
        bus.flush_req_i = 1; cyc(); bus.flush_req_i = 0;
        repeat (NS + 3) cyc();
        repeat (2000) begin
            int r = int'($urandom_range(0, 99));
            bit busy_m = sweep >= 0;
            idle_inputs();
            bus.flush_req_i = r < 1;
            bus.cline_index_i = 6'($urandom_range(0, 7));
            bus.way_valid_bits_i = $urandom_range(0, 9) < 7 ? 4'hF : 4'($urandom_range(0, 15));
            bus.hit_i = 1'($urandom_range(0, 1));
            bus.hit_way_i = 2'($urandom_range(0, 3));
            bus.cmp_en_i = !busy_m && $urandom_range(0, 2) == 0;
            if (r >= 90) begin
                bus.inval_valid_i = 1;
                bus.inval_idx_i = 6'($urandom_range(0, 7));
            end else if (!busy_m) begin
                bus.cache_rd_ena_i = 1'($urandom_range(0, 1));
                bus.cache_wr_ena_i = $urandom_range(0, 3) == 0;
            end
            cyc();
        end
        idle_inputs();
        cyc();
        for (int k = 0; k < 10 && q.size() > 0; k++) begin
            @(negedge clk);
            #1;
        end
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sargantana_icache_replace_ctrl.md
# sargantana_icache_replace_ctrl

Parametrised replacement and valid-bit controller for the Sargantana instruction cache. It supersedes the single-cycle replace unit and adds three capabilities:
- a per-set tree-PLRU victim policy, selectable at compile time, alongside an LFSR fallback;
- a sequential flush engine that sweeps every set to clear valid bits;
- a ready/valid handshake for single-set invalidations.

It sits between the icache controller FSM and the tag/valid/data RAM enables.

## Interface
Parameters:
- ICACHE_N_WAY, 4, number of ways; power of two, 2..8.
- ICACHE_IDX_WIDTH, 6, set-index width; number of sets N_SET = 2^ICACHE_IDX_WIDTH.

Ports (W = $clog2(ICACHE_N_WAY)):
- clk_i  in  1  clock; all state updates on the rising edge.
- rstn_i  in  1  reset, asynchronous, active-low.
- flush_req_i  in  1  request a full-cache valid-bit sweep (level).
- busy_o  out  1  high while the sweep runs; the core must not issue rd/wr while it is high.
- flush_done_o  out  1  one-cycle pulse when the sweep completes.
- inval_valid_i  in  1  single-set invalidation request.
- inval_idx_i  in  ICACHE_IDX_WIDTH  set to invalidate.
- inval_ready_o  out  1  invalidation accepted when inval_valid_i & inval_ready_o.
- cache_rd_ena_i  in  1  lookup read.
- cache_wr_ena_i  in  1  refill write into the captured way.
- cline_index_i  in  ICACHE_IDX_WIDTH  set index from the core.
- way_valid_bits_i  in  ICACHE_N_WAY  valid bits of the looked-up set.
- cmp_en_i  in  1  tag-compare cycle; captures the victim.
- hit_i  in  1  lookup hit (qualifies hit_way_i).
- hit_way_i  in  W  hitting way, binary.
- way_to_replace_o  out  W  registered victim way.
- addr_valid_o  out  ICACHE_IDX_WIDTH  index to the valid/tag RAM.
- tag_req_valid_o  out  ICACHE_N_WAY  tag/valid RAM enables.
- data_req_valid_o  out  ICACHE_N_WAY  data RAM enables.
- we_valid_o  out  1  valid-bit write enable.
- valid_bit_o  out  1  value written to the valid bit.

## Operation
FSM states: IDLE, FLUSH, DONE.
- IDLE → FLUSH on flush_req_i. On entry, sweep counter cnt = 0.
- FLUSH advances cnt by 1 each cycle. When cnt = N_SET-1 it goes to DONE. flush_req_i is ignored while in FLUSH.
- DONE → IDLE after one cycle. A flush_req_i still held high is accepted from IDLE on the following cycle.

RAM command priority (combinational, one per cycle): FLUSH > accepted inval > wr > rd > none.
- FLUSH: addr_valid_o=cnt, tag_req_valid_o='1, data_req_valid_o='0, we_valid_o=1, valid_bit_o=0. Policy state of set cnt is cleared.
- Inval: inval_ready_o = (state==IDLE) & ~flush_req_i. On acceptance: addr=inval_idx_i, tag_req='1, data_req='0, we=1, valid_bit=0. Policy state of that set is cleared.
- Wr: addr=cline_index_i, tag_req = data_req = onehot(way_to_replace_o), we=1, valid_bit=1.
- Rd: addr=cline_index_i, tag_req='1, data_req='1, we=0.
- None: addr=cline_index_i, all enables 0, we=0, valid_bit=0.
- An invalidation that is not accepted leaves rd/wr unaffected.

Victim selection, registered when cmp_en_i is high:
- If any bit of way_valid_bits_i is 0, the victim is the lowest-index invalid way.
- Otherwise the victim comes from the compiled policy (see Configuration).
- way_to_replace_o holds its value otherwise.

Policy update:
- On a refill write, toward way_to_replace_o.
- On rd & hit_i, toward hit_way_i.
- If a refill and a hit occur in the same cycle, only the refill updates.

## Timing
- Reset values: way_to_replace_o=0, busy_o=0, flush_done_o=0, state IDLE, cnt=0, all PLRU bits 0, LFSR=16'hACE1.
- Combinational outputs at reset follow the "none" row (inval_ready_o=1 unless flush_req_i is high).
- Flush latency: busy_o rises the cycle after flush_req_i is sampled and stays high exactly N_SET cycles. flush_done_o pulses the next cycle, while busy_o=0.
- Victim capture: 1 cycle; way_to_replace_o is valid the cycle after cmp_en_i.
- Reset asserted mid-flush aborts the sweep: IDLE, no flush_done_o pulse, and RAM valid bits are left partially cleared. The controller must re-request the flush.
- cnt wraps to 0 only via DONE, never within FLUSH.

## Configuration
- ICACHE_PLRU_EN defined: per-set tree PLRU, ICACHE_N_WAY-1 flops per set.
  - Node 0 is the root; node i has children 2i+1 and 2i+2.
  - Bit 0 means the victim lies in the lower-way subtree.
  - An access sets each node on its path to point away from the accessed way.
- ICACHE_PLRU_EN undefined: no PLRU storage.
  - 16-bit Fibonacci LFSR, taps x^16+x^14+x^13+x^11+1.
  - Victim = LFSR[W-1:0].
  - The LFSR advances on every refill write while the captured set was fully valid.
  - Policy-clear actions are no-ops.

## Test plan
- Reset, then flush_req_i one cycle (IDX=6): busy_o high for 64 cycles, addr_valid_o steps 0..63 with we=1, valid_bit=0; flush_done_o pulses once at cycle 65.
- way_valid_bits_i=4'b1011, cmp_en_i: way_to_replace_o=2. Then wr: data_req_valid_o=4'b0100, valid_bit_o=1.
- PLRU build, 4 ways, all valid, set 5: hit way 0 → capture gives victim 2; then hit way 2 → victim 1.
- inval_valid_i with idx 5 during FLUSH: inval_ready_o=0 until IDLE, then accepted with addr=5 and we=1. Afterwards set 5 PLRU is cleared, so victim = 0 when all valid.
- rd+hit and wr in the same cycle: wr command driven, and the PLRU update follows way_to_replace_o only.
- rstn_i low at cnt=20 mid-flush: busy_o=0 immediately, no flush_done_o; a new flush restarts at addr 0.
